// File: rtl/demux_1_8_stream_if.sv
// Stream bundle for the 1-to-8 demultiplexer: the producer side plus eight consumer channels.
// The slave modport is the block's view. The master modport is the surrounding producer/consumer logic.
interface demux_1_8_stream_if #(
    parameter int DATA_LENGTH = 8
);
    logic [DATA_LENGTH-1:0]   in_data;
    logic [2:0]               in_sel;
    logic                     in_valid;
    logic                     in_ready;
    logic [8*DATA_LENGTH-1:0] out_data;
    logic [7:0]               out_valid;
    logic [7:0]               out_ready;
    logic                     pending;

    modport slave (
        input  in_data,
        input  in_sel,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output pending
    );

    modport master (
        output in_data,
        output in_sel,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  pending
    );
endinterface

// File: rtl/demux_1_8_stream.sv
// Registered 1-to-8 stream demultiplexer: in_sel steers each accepted word into one of
// eight one-entry holding registers, and every channel drains independently.
module demux_1_8_stream #(
    parameter int DATA_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    demux_1_8_stream_if.slave      bus
);

    localparam int N_CH = 8;

    logic [N_CH-1:0][DATA_LENGTH-1:0] hold_data_q;
    logic [N_CH-1:0][DATA_LENGTH-1:0] hold_data_d;
    logic [N_CH-1:0]                  hold_valid_q;
    logic [N_CH-1:0]                  hold_valid_d;

    logic            sel_ready;
    logic            accept;
    logic [N_CH-1:0] drain;

    // Readiness looks only at the selected channel. A channel that is draining on this
    // edge can take a new word, which gives one word per cycle per channel.
    assign sel_ready    = ~hold_valid_q[bus.in_sel] | bus.out_ready[bus.in_sel];
    assign bus.in_ready = rst_n & sel_ready;

    assign accept = bus.in_valid & bus.in_ready;
    assign drain  = hold_valid_q & bus.out_ready;

    // NOTE: every variable written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q & ~drain;
        if (accept) begin
            hold_data_d[bus.in_sel]  = bus.in_data;
            hold_valid_d[bus.in_sel] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so that every flop samples
    // values from before the edge, whatever order the simulator runs the blocks in.
    // NOTE: the data registers are reset as well as the flags, because out_data has to
    // read as zero while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data_q  <= '0;
            hold_valid_q <= '0;
        end else begin
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign bus.out_data  = hold_data_q;
    assign bus.out_valid = hold_valid_q;
    assign bus.pending   = |hold_valid_q;

endmodule

// File: doc/demux_1_8_stream.md
# demux_1_8_stream

Registered 1-to-8 stream demultiplexer with valid/ready handshakes: a single producer stream is steered by a 3-bit select to one of eight output channels, each backed by a one-entry holding register. It is the distributing counterpart of the team's 8:1 selection muxes. It sits between a shared result/writeback source and eight independent consumers, such as peripheral or register-bank write ports, that may stall individually.

## Interface
Parameters:
- DATA_LENGTH, 8, width of each data word.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- in_data  in  DATA_LENGTH  producer data word.
- in_sel  in  3  destination channel index, 0..7.
- in_valid  in  1  producer offers in_data/in_sel this cycle.
- in_ready  out  1  block accepts this cycle; combinational.
- out_data  out  8*DATA_LENGTH  packed channel data; channel i occupies bits [i*DATA_LENGTH +: DATA_LENGTH]; registered.
- out_valid  out  8  per-channel holding register full; registered.
- out_ready  in  8  per-channel consumer accepts.
- pending  out  1  OR of out_valid; combinational from registers.

## Operation
- Per channel i, state is hold_data[i] (DATA_LENGTH bits) and hold_valid[i] (1 bit). out_data slice i = hold_data[i]; out_valid[i] = hold_valid[i].
- in_ready = rst_n & (~hold_valid[in_sel] | out_ready[in_sel]).
  - Depends only on the selected channel. Other channels being full never blocks.
  - in_ready may depend on in_sel and out_ready combinationally. It must not depend on in_valid.
- Accept event: in_valid & in_ready at a rising edge.
  - hold_data[in_sel] <= in_data and hold_valid[in_sel] <= 1.
- Drain event for channel i: out_valid[i] & out_ready[i] at a rising edge.
  - hold_valid[i] <= 0 unless the same edge accepts into channel i.
- Simultaneous drain and accept on the same channel: the old word is consumed, the new word is loaded, and valid stays 1. This gives full throughput, one word per cycle per channel.
- Drains on different channels are independent. Any subset of the eight may drain in one cycle, concurrently with one accept on any channel.
- hold_data[i] holds its value while hold_valid[i]=1 and no accept targets i. After a drain it keeps its last value; consumers must qualify it with out_valid.
- Producer side: in_data/in_sel may change freely while in_valid=0. The block does not require the producer to hold data stable under backpressure; producers follow the usual valid/ready rules.
- in_sel is always a legal 0..7. No default/illegal channel exists.
- There is no FSM beyond the eight 1-bit full/empty flags. Each flag has two states:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on drain+accept or when idle.

## Timing
- Reset values, applied immediately on rst_n falling, with no clock required:
  - hold_valid = 0, so out_valid = 8'h00.
  - hold_data = 0, so out_data = all zeros.
  - pending = 0.
  - in_ready = 0 while rst_n=0.
- First rising edge after rst_n rises may accept.
- Latency: a word accepted at edge N appears on out_data/out_valid of its channel after edge N. It can be drained at edge N+1.
- Throughput: one accept per cycle total. Up to eight drains per cycle.
- Reset mid-operation: all held words are discarded. No out_valid pulse follows deassertion.
- No combinational path from in_data to any output. out_data and out_valid are purely registered.

## Test plan
- Reset: drive rst_n=0 mid-stream with channels 2 and 5 full -> out_valid=8'h00, out_data=0, pending=0, in_ready=0 asynchronously. After release, in_ready=1 with out_ready=0.
- Basic routing: DATA_LENGTH=8. Send 8'hA0+i to in_sel=i for i=0..7, one per cycle, with out_ready=8'h00 -> after 8 edges out_valid=8'hFF and slice i = 8'hA0+i. A 9th offer to sel=3 sees in_ready=0.
- Per-channel backpressure: channel 3 full with out_ready[3]=0, offer sel=3 -> in_ready=0. Offer sel=4 with channel 4 empty -> in_ready=1, accepted, and channel 3 still holds its old word.
- Full throughput: hold out_ready[6]=1 and stream 8'h11, 8'h22, 8'h33 to sel=6 on consecutive cycles -> in_ready=1 every cycle. Consumer sees each word for exactly one cycle, in order, with no gap.
- Simultaneous drain and accept: channel 1 holds 8'h55, out_ready[1]=1, accept 8'h66 to sel=1 on the same edge -> out_valid[1] stays 1 and out_data slice 1 = 8'h66 next cycle.
- Parallel drains: channels 0, 2 and 7 full, out_ready=8'b1000_0101, no accept -> out_valid clears to 8'h00 in one edge and pending falls to 0.
